// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and hazard helper for pipe_hazard_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } pipe_state_t;

  localparam int WAIT_CNT_W = 8;

  // A load in EX whose destination feeds the instruction in ID; x0 never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       id_valid,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       ex_memread,
    input logic [4:0] ex_rd
  );
    return id_valid & ex_memread & (ex_rd != 5'd0) &
           ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - consecutive memory-stall counter with timeout compare
module wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  output logic timeout
);

  localparam logic [WAIT_CNT_W:0] MAX_W = (WAIT_CNT_W + 1)'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_CNT_W:0]   cnt_next;

  // Timeout fires in the stall cycle that brings the run length up to MAX_WAIT.
  always_comb begin
    cnt_next = {1'b0, cnt_q} + {{WAIT_CNT_W{1'b0}}, 1'b1};
    timeout  = stall & (cnt_next == MAX_W);
    cnt_d    = '0;
    if (stall && !timeout) begin
      cnt_d = cnt_next[WAIT_CNT_W-1:0];
    end
  end

  // Counter register; any non-stall cycle restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard/stall controller; optional PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_memread,
  input  logic       mem_memwrite,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       memwb_bubble,
  output logic       mem_err,
  output logic [1:0] state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  pipe_state_t state_q, state_d;
  logic        req_hold_q, req_hold_d;
  logic        mem_err_q, mem_err_d;
  logic        mem_stall;
  logic        timeout;
  logic        branch;
  logic        load_use;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (mem_stall),
    .timeout (timeout)
  );

  // Stage controls and next state; everything is forced to the idle pattern while in reset.
  always_comb begin
    dmem_req     = rst_n & ~mem_err_q & (mem_memread | mem_memwrite | req_hold_q);
    mem_stall    = dmem_req & ~dmem_ready;
    // EX holds a bubble during FLUSH and ID/EX was just flushed during LOAD_STALL,
    // so a repeat branch or load-use there would be stale; this keeps both states one cycle long.
    branch       = rst_n & ex_branch_taken & (state_q != ST_FLUSH);
    load_use     = rst_n & (state_q != ST_LOAD_STALL) &
                   load_use_hazard(id_valid, id_rs1, id_rs2, ex_memread, ex_rd);
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = ST_RUN;
    if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = timeout ? ST_RUN : ST_MEM_WAIT;
    end else if (branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_FLUSH;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = ST_LOAD_STALL;
    end
    // The request stays asserted across wait states until the memory answers or times out.
    req_hold_d = mem_stall & ~timeout;
    mem_err_d  = mem_err_q | timeout;
  end

  // FSM state, request hold and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      req_hold_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_hold_q <= req_hold_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters; natural 32-bit wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en};
    flush_cnt_d = flush_cnt_q + {31'd0, ifid_flush};
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed table-driven bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_memread, mem_memwrite, dmem_ready;
  logic       dmem_req, pc_en, ifid_en, exmem_en;
  logic       ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // {dmem_req, pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
  logic [6:0] outs;
  assign outs = {dmem_req, pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  localparam logic [6:0] O_IDLE  = 7'b0111000;
  localparam logic [6:0] O_LU    = 7'b0001010;
  localparam logic [6:0] O_BR    = 7'b0111110;
  localparam logic [6:0] O_MEMOK = 7'b1111000;
  localparam logic [6:0] O_STALL = 7'b1000001;

  pipe_hazard_ctrl #(.MAX_WAIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_memread     (mem_memread),
    .mem_memwrite    (mem_memwrite),
    .dmem_ready      (dmem_ready),
    .dmem_req        (dmem_req),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .mem_err         (mem_err),
    .state           (state)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       exr;
    logic [4:0] rd;
    logic       br;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [6:0] exp_out;
    logic [1:0] exp_ns;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_memread = 0; ex_rd = 0;
    ex_branch_taken = 0; mem_memread = 0; mem_memwrite = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_outs", {25'd0, outs}, {25'd0, O_IDLE});
    check("reset_mem_err", {31'd0, mem_err}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // lw x5 / add x6,x5,x7
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  2'd0};
    vecs[1]  = '{1'b1, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,    2'd1};
    vecs[2]  = '{1'b1, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,    2'd1};
    vecs[3]  = '{1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  2'd0};
    vecs[4]  = '{1'b0, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  2'd0};
    vecs[5]  = '{1'b1, 5'd5, 5'd7, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  2'd0};
    vecs[6]  = '{1'b1, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_BR,    2'd3};
    vecs[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_BR,    2'd3};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_MEMOK, 2'd0};
    vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_STALL, 2'd2};
    vecs[10] = '{1'b1, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_STALL, 2'd2};
    vecs[11] = '{1'b1, 5'd4, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,  2'd0};

    idle_inputs();
    do_reset();

    // Store with three wait states; request held even when the flag drops.
    mem_memwrite = 1; dmem_ready = 0;
    #1;
    check("sw_wait1_outs", {25'd0, outs}, {25'd0, O_STALL});
    tick();
    check("sw_state_memwait", {30'd0, state}, 32'd2);
    mem_memwrite = 0;
    #1;
    check("sw_wait2_hold", {25'd0, outs}, {25'd0, O_STALL});
    tick();
    check("sw_wait3_outs", {25'd0, outs}, {25'd0, O_STALL});
    tick();
    dmem_ready = 1;
    #1;
    check("sw_ready_outs", {25'd0, outs}, {25'd0, O_MEMOK});
    check("sw_ready_state", {30'd0, state}, 32'd2);
    tick();
    dmem_ready = 0;
    #1;
    check("sw_after_state", {30'd0, state}, 32'd0);
    check("sw_after_outs", {25'd0, outs}, {25'd0, O_IDLE});
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall_cnt", stall_cnt, 32'd3);
    check("perf_flush_cnt", flush_cnt, 32'd0);
`endif

    do_reset();

    // Single-cycle vectors, each applied from RUN and then drained back to RUN.
    for (int i = 0; i < 12; i++) begin
      id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      ex_memread = vecs[i].exr; ex_rd = vecs[i].rd; ex_branch_taken = vecs[i].br;
      mem_memread = vecs[i].mr; mem_memwrite = vecs[i].mw; dmem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_outs", i), {25'd0, outs}, {25'd0, vecs[i].exp_out});
      tick();
      check($sformatf("vec%0d_next_state", i), {30'd0, state}, {30'd0, vecs[i].exp_ns});
      idle_inputs();
      dmem_ready = 1;
      tick();
      dmem_ready = 0;
      tick();
      check($sformatf("vec%0d_back_to_run", i), {30'd0, state}, 32'd0);
    end

    // Load-use held for two cycles still stalls only once.
    id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd7; ex_memread = 1; ex_rd = 5'd5;
    tick();
    #1;
    check("lu_second_cycle_pc_en", {31'd0, pc_en}, 32'd1);
    idle_inputs();
    tick();
    check("lu_return_run", {30'd0, state}, 32'd0);

    // Reset in the middle of a wait.
    mem_memread = 1; dmem_ready = 0;
    tick();
    tick();
    check("rstwait_state_pre", {30'd0, state}, 32'd2);
    rst_n = 0;
    #1;
    check("rstwait_state", {30'd0, state}, 32'd0);
    check("rstwait_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rstwait_mem_err", {31'd0, mem_err}, 32'd0);
    check("rstwait_outs", {25'd0, outs}, {25'd0, O_IDLE});
    mem_memread = 0;
    #3;
    rst_n = 1;
    tick();
    check("rstwait_release_outs", {25'd0, outs}, {25'd0, O_IDLE});
    check("rstwait_release_state", {30'd0, state}, 32'd0);

    // Timeout with MAX_WAIT=4.
    mem_memread = 1; dmem_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("to_stall%0d_pc_en", c), {31'd0, pc_en}, 32'd0);
      check($sformatf("to_stall%0d_mem_err", c), {31'd0, mem_err}, 32'd0);
      tick();
    end
    check("to_mem_err", {31'd0, mem_err}, 32'd1);
    check("to_outs", {25'd0, outs}, {25'd0, O_IDLE});
    check("to_state", {30'd0, state}, 32'd0);
    tick();
    check("to_mem_err_sticky", {31'd0, mem_err}, 32'd1);
    check("to_dmem_req_off", {31'd0, dmem_req}, 32'd0);
    idle_inputs();
    do_reset();
    check("to_cleared_by_reset", {31'd0, mem_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, maximum data-memory wait cycles before timeout (range 1..255).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: id_valid  in  1  ID stage holds a real instruction; id_rs1, id_rs2  in  5 each  ID source registers.
REQ-005 SHALL have ports: ex_memread  in  1  ID/EX MemRead; ex_rd  in  5  ID/EX destination; ex_branch_taken  in  1  branch resolved taken in EX.
REQ-006 SHALL have ports: mem_memread, mem_memwrite  in  1 each  EX/MEM access flags; dmem_ready  in  1  data memory completes access.
REQ-007 SHALL have ports: dmem_req  out  1  access request; pc_en, ifid_en, exmem_en  out  1 each  stage enables.
REQ-008 SHALL have ports: ifid_flush, idex_flush, memwb_bubble  out  1 each  bubble inserts; mem_err  out  1  sticky timeout flag; state  out  2  current FSM state.

Function
REQ-009 SHALL implement registered FSM with states RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3; stage controls are combinational from state and inputs (zero-cycle latency).
REQ-010 SHALL drive dmem_req = mem_memread | mem_memwrite while mem_err=0; once raised it stays high until the cycle dmem_ready=1.
REQ-011 SHALL define mem_stall = dmem_req & ~dmem_ready; when set: pc_en=ifid_en=exmem_en=0, memwb_bubble=1, no flushes, next state MEM_WAIT.
REQ-012 SHALL leave MEM_WAIT to RUN in the cycle after dmem_ready=1; dmem_ready in the request cycle means zero wait states and no MEM_WAIT entry.
REQ-013 SHALL count consecutive mem_stall cycles in an 8-bit counter; on reaching MAX_WAIT set mem_err, force dmem_req=0, release stall, return to RUN; counter clears on any non-stall cycle.
REQ-014 SHALL, absent mem_stall, on ex_branch_taken: ifid_flush=idex_flush=1, pc_en=1, next state FLUSH for exactly one cycle, then RUN.
REQ-015 SHALL detect load-use = id_valid & ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-016 SHALL, absent mem_stall and branch, on load-use: pc_en=ifid_en=0, idex_flush=1, next state LOAD_STALL for exactly one cycle, then RUN.
REQ-017 SHALL use priority mem_stall > branch flush > load-use; simultaneous branch and load-use gives flush only, no stall.
REQ-018 SHALL in all other cases drive pc_en=ifid_en=exmem_en=1 and all flush/bubble outputs 0.
REQ-019 SHALL clear mem_err only by reset.

Reset
REQ-020 SHALL on rst_n=0, asynchronously: state=RUN, wait counter=0, mem_err=0, perf counters=0.
REQ-021 SHALL while rst_n=0 force dmem_req=0, all flush/bubble outputs 0, all enables 1.
REQ-022 SHALL abandon an in-progress MEM_WAIT on reset mid-wait with no residual stall after release.

Configuration
REQ-023 SHALL, with PIPE_PERF_CNT_EN defined, add outputs stall_cnt and flush_cnt (32 bits each): stall_cnt increments per cycle pc_en=0, flush_cnt per cycle ifid_flush=1; both wrap at 2^32.
REQ-024 SHALL, without PIPE_PERF_CNT_EN, omit both ports and counters entirely.

Structure
REQ-025 SHALL place the state enum (pipe_state_t) and state encodings in shared package pipe_ctrl_pkg.
REQ-026 SHALL implement the wait counter and timeout compare as sub-module wait_timer.

Verification
REQ-027 SHALL cover: lw x5 in EX, add using x5 in ID -> one cycle pc_en=0, idex_flush=1, state=1, then RUN.
REQ-028 SHALL cover: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall.
REQ-029 SHALL cover: ex_branch_taken=1 with load-use hazard present -> ifid_flush=idex_flush=1, pc_en=1, no stall, state=3 next cycle.
REQ-030 SHALL cover: sw with dmem_ready low 3 cycles -> 3 cycles pc_en=exmem_en=0, memwb_bubble=1, dmem_req held, RUN after ready.
REQ-031 SHALL cover: MAX_WAIT=4, dmem_ready never high -> mem_err=1 after 4 stall cycles, dmem_req=0, enables 1.
REQ-032 SHALL cover: rst_n low during MEM_WAIT -> state=0, dmem_req=0, mem_err=0 immediately; PIPE_PERF_CNT_EN build shows stall_cnt=3 after the REQ-030 scenario.
